// File: rtl/box_frame_sequencer.sv
// Frame-paced erase/move/redraw sequencer for the bouncing-box VGA datapath.
// Optional build macro TRAIL_EN: draw-then-move sequence without erasing (leaves a trail).
module box_frame_sequencer #(
    parameter int FRAME_CYCLES = 833334,
    parameter int BOX_W        = 4,
    parameter int BOX_H        = 4,
    parameter int X_MAX        = 156,
    parameter int Y_MAX        = 116
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int             CW       = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [3:0]     OX_LAST  = 4'(BOX_W - 1);
    localparam logic [3:0]     OY_LAST  = 4'(BOX_H - 1);
    localparam logic [7:0]     XM       = 8'(X_MAX);
    localparam logic [6:0]     YM       = 7'(Y_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MOVE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] frame_cnt;
    logic          tick;
    logic [7:0]    pos_x, pos_x_d;
    logic [6:0]    pos_y, pos_y_d;
    logic          dir_x, dir_x_d, dir_y, dir_y_d;
    logic [2:0]    col_q, col_d;
    logic [3:0]    off_x, off_x_d, off_y, off_y_d;
    logic          scan_last, nx, ny;
    logic [7:0]    x_d;
    logic [6:0]    y_d;
    logic [2:0]    colour_d;
    logic          plot_d, busy_d, done_d, overrun_d;

    assign tick = enable && (frame_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (enable) begin
            frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d   = state;
        pos_x_d   = pos_x;
        pos_y_d   = pos_y;
        dir_x_d   = dir_x;
        dir_y_d   = dir_y;
        col_d     = col_q;
        off_x_d   = off_x;
        off_y_d   = off_y;
        scan_last = (off_x == OX_LAST) && (off_y == OY_LAST);
        nx        = (pos_x == XM) ? 1'b0 : (pos_x == 8'd0) ? 1'b1 : dir_x;
        ny        = (pos_y == YM) ? 1'b0 : (pos_y == 7'd0) ? 1'b1 : dir_y;

        case (state)
            S_IDLE: begin
                if (tick) begin
                    col_d   = colour_in;
                    off_x_d = 4'd0;
                    off_y_d = 4'd0;
`ifdef TRAIL_EN
                    state_d = S_DRAW;
`else
                    state_d = S_CLEAR;
`endif
                end
            end
            S_CLEAR, S_DRAW: begin
                if (scan_last) begin
                    off_x_d = 4'd0;
                    off_y_d = 4'd0;
`ifdef TRAIL_EN
                    state_d = S_MOVE;
`else
                    state_d = (state == S_CLEAR) ? S_MOVE : S_DONE;
`endif
                end else if (off_x == OX_LAST) begin
                    off_x_d = 4'd0;
                    off_y_d = off_y + 4'd1;
                end else begin
                    off_x_d = off_x + 4'd1;
                end
            end
            S_MOVE: begin
                // Bouncing at an edge forces the direction away from it; corners flip both axes.
                dir_x_d = nx;
                dir_y_d = ny;
                pos_x_d = nx ? pos_x + 8'd1 : pos_x - 8'd1;
                pos_y_d = ny ? pos_y + 7'd1 : pos_y - 7'd1;
                off_x_d = 4'd0;
                off_y_d = 4'd0;
`ifdef TRAIL_EN
                state_d = S_DONE;
`else
                state_d = S_DRAW;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register alongside it (Moore, 1-cycle tick latency).
        plot_d    = (state_d == S_CLEAR) || (state_d == S_DRAW);
        x_d       = pos_x_d + {4'd0, off_x_d};
        y_d       = pos_y_d + {3'd0, off_y_d};
        colour_d  = (state_d == S_DRAW) ? col_d : 3'd0;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        overrun_d = overrun | (tick && (state != S_IDLE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pos_x      <= 8'd0;
            pos_y      <= 7'd0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            col_q      <= 3'd0;
            off_x      <= 4'd0;
            off_y      <= 4'd0;
            x          <= 8'd0;
            y          <= 7'd0;
            colour     <= 3'd0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            pos_x      <= pos_x_d;
            pos_y      <= pos_y_d;
            dir_x      <= dir_x_d;
            dir_y      <= dir_y_d;
            col_q      <= col_d;
            off_x      <= off_x_d;
            off_y      <= off_y_d;
            x          <= x_d;
            y          <= y_d;
            colour     <= colour_d;
            plot       <= plot_d;
            busy       <= busy_d;
            frame_done <= done_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_box_frame_sequencer.sv
// Directed bench for box_frame_sequencer: timing, raster scan, bounce, reset abort and overrun.
module tb_box_frame_sequencer;

`ifdef TRAIL_EN
    localparam int SEQ = 18, DRAW_START = 0, FCB = 12, PLOTS = 16;
`else
    localparam int SEQ = 34, DRAW_START = 17, FCB = 20, PLOTS = 32;
`endif

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] colour_in = 3'd0;
    logic       sel_c = 1'b0;

    logic [7:0] x_a, x_b, x_c;
    logic [6:0] y_a, y_b, y_c;
    logic [2:0] c_a, c_b, c_c;
    logic       plot_a, plot_b, plot_c, busy_a, busy_b, busy_c;
    logic       fd_a, fd_b, fd_c, ov_a, ov_b, ov_c;

    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    logic       m_plot, m_busy, m_fd;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    box_frame_sequencer #(.FRAME_CYCLES(40)) dut_a (
        .clk(clk), .reset(rst_a), .enable(enable), .colour_in(colour_in),
        .x(x_a), .y(y_a), .colour(c_a), .plot(plot_a), .busy(busy_a),
        .frame_done(fd_a), .overrun(ov_a)
    );

    box_frame_sequencer #(.FRAME_CYCLES(FCB)) dut_b (
        .clk(clk), .reset(rst_b), .enable(enable), .colour_in(colour_in),
        .x(x_b), .y(y_b), .colour(c_b), .plot(plot_b), .busy(busy_b),
        .frame_done(fd_b), .overrun(ov_b)
    );

    box_frame_sequencer #(.FRAME_CYCLES(40), .X_MAX(6), .Y_MAX(2)) dut_c (
        .clk(clk), .reset(rst_c), .enable(enable), .colour_in(colour_in),
        .x(x_c), .y(y_c), .colour(c_c), .plot(plot_c), .busy(busy_c),
        .frame_done(fd_c), .overrun(ov_c)
    );

    assign m_x    = sel_c ? x_c    : x_a;
    assign m_y    = sel_c ? y_c    : y_a;
    assign m_c    = sel_c ? c_c    : c_a;
    assign m_plot = sel_c ? plot_c : plot_a;
    assign m_busy = sel_c ? busy_c : busy_a;
    assign m_fd   = sel_c ? fd_c   : fd_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_plot(input string tag, input int limit);
        int n;
        n = 0;
        while (!m_plot && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_plot_rise"}, {31'd0, m_plot}, 32'd1);
    endtask

    // Checks n cycles starting at the first plot: clear at (ox0,oy0), gap, draw at (ox1,oy1), done.
    task automatic check_seq(input string tag, input logic [7:0] ox0, input logic [6:0] oy0,
                             input logic [7:0] ox1, input logic [6:0] oy1,
                             input logic [2:0] col, input int n);
        for (int i = 0; i < n; i++) begin
            logic       ep, efd, eb;
            logic [7:0] ex;
            logic [6:0] ey;
            logic [2:0] ec;
            logic [20:0] g, e;
            int k;
            ep = 1'b0; efd = 1'b0; ex = 8'd0; ey = 7'd0; ec = 3'd0; k = 0;
            eb = (i < SEQ);
`ifdef TRAIL_EN
            if (i < 16) begin
                ep = 1'b1; ex = ox0 + 8'(i % 4); ey = oy0 + 7'(i / 4); ec = col;
            end else if (i == 17) begin
                efd = 1'b1;
            end
`else
            if (i < 16) begin
                ep = 1'b1; ex = ox0 + 8'(i % 4); ey = oy0 + 7'(i / 4); ec = 3'd0;
            end else if (i >= 17 && i < 33) begin
                k = i - 17;
                ep = 1'b1; ex = ox1 + 8'(k % 4); ey = oy1 + 7'(k / 4); ec = col;
            end else if (i == 33) begin
                efd = 1'b1;
            end
`endif
            g = {m_busy, m_fd, m_plot, ep ? {m_c, m_y, m_x} : 18'd0};
            e = {eb, efd, ep, ec, ey, ex};
            check($sformatf("%s_cyc%0d", tag, i), {11'd0, g}, {11'd0, e});
            if (i == 20 || i == 28) colour_in = ~colour_in;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {7'd0, x_a, y_a, c_a, plot_a, busy_a, fd_a, ov_a}, 32'd0);

        // First tick latency and first sequence at colour 101
        rst_a = 1'b0; enable = 1'b1; colour_in = 3'b101;
        repeat (39) @(negedge clk);
        check("t1_no_early_plot", {31'd0, plot_a}, 32'd0);
        @(negedge clk);
        check("t1_first_plot", {31'd0, plot_a}, 32'd1);
        check_seq("t1", 8'd0, 7'd0, 8'd1, 7'd1, 3'b101, SEQ + 1);

        // Second frame, abandoned by reset at draw pixel 7
        colour_in = 3'b111;
        wait_plot("t3", 60);
        check_seq("t3", 8'd1, 7'd1, 8'd2, 7'd2, 3'b111, DRAW_START + 7);
        rst_a = 1'b1;
        #1;
        check("t3_reset_plot", {31'd0, plot_a}, 32'd0);
        check("t3_reset_xy", {17'd0, x_a, y_a}, 32'd0);
        check("t3_reset_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0; colour_in = 3'b100;
        wait_plot("t3b", 60);
        check_seq("t3_after", 8'd0, 7'd0, 8'd1, 7'd1, 3'b100, SEQ + 1);

        // Enable held low for 50 cycles delays the tick by 50; colour_in toggles mid-draw
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; enable = 1'b1; colour_in = 3'b011;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        enable = 1'b1;
        repeat (29) @(negedge clk);
        check("t5_no_early_plot", {31'd0, plot_a}, 32'd0);
        @(negedge clk);
        check("t5_delayed_plot", {31'd0, plot_a}, 32'd1);
        check_seq("t5", 8'd0, 7'd0, 8'd1, 7'd1, 3'b011, SEQ + 1);

        // Edge bounces on the default playfield
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; colour_in = 3'b001;
        for (int k = 1; k <= 157; k++) begin
            wait_plot($sformatf("bounce_f%0d", k), 60);
            case (k)
                1:       check_seq("f1",   8'd0,   7'd0,   8'd1,   7'd1,   3'b001, SEQ + 1);
                116:     check_seq("f116", 8'd115, 7'd115, 8'd116, 7'd116, 3'b001, SEQ + 1);
                117:     check_seq("f117", 8'd116, 7'd116, 8'd117, 7'd115, 3'b001, SEQ + 1);
                156:     check_seq("f156", 8'd155, 7'd77,  8'd156, 7'd76,  3'b001, SEQ + 1);
                157:     check_seq("f157", 8'd156, 7'd76,  8'd155, 7'd75,  3'b001, SEQ + 1);
                default: repeat (SEQ + 1) @(negedge clk);
            endcase
        end
        rst_a = 1'b1;

        // Corner on a small playfield (X_MAX=6, Y_MAX=2)
        sel_c = 1'b1; colour_in = 3'b010;
        @(negedge clk);
        rst_c = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            wait_plot($sformatf("corner_f%0d", k), 60);
            case (k)
                3:       check_seq("c3", 8'd2, 7'd2, 8'd3, 7'd1, 3'b010, SEQ + 1);
                7:       check_seq("c7", 8'd6, 7'd2, 8'd5, 7'd1, 3'b010, SEQ + 1);
                9:       check_seq("c9", 8'd4, 7'd0, 8'd3, 7'd1, 3'b010, SEQ + 1);
                default: repeat (SEQ + 1) @(negedge clk);
            endcase
        end
        rst_c = 1'b1;
        sel_c = 1'b0;

        // Frame period shorter than the sequence: dropped tick sets sticky overrun
        check("ov_reset", {31'd0, ov_b}, 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        repeat (FCB) @(negedge clk);
        check("ov_first_plot", {31'd0, plot_b}, 32'd1);
        check("ov_clear_before", {31'd0, ov_b}, 32'd0);
        np = 0;
        for (int i = 0; i < SEQ; i++) begin
            if (plot_b) np++;
            @(negedge clk);
        end
        check("ov_plot_count", np, PLOTS);
        check("ov_set", {31'd0, ov_b}, 32'd1);
        check("ov_idle_after", {31'd0, busy_b}, 32'd0);
        repeat (3 * FCB) @(negedge clk);
        check("ov_sticky", {31'd0, ov_b}, 32'd1);
        rst_b = 1'b1;
        #1;
        check("ov_cleared_by_reset", {31'd0, ov_b}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
